// File: rtl/fifo_write_arbiter.sv
// -----------------------------------------------------------------------------
// fifo_write_arbiter
//
// Round-robin arbiter sharing the single write port of the async FIFO among
// NUM_REQ requesters. Lives in the FIFO write-clock domain. One requester owns
// the port at a time and may write at most MAX_BURST consecutive words before
// it must release it. Each change of owner costs one idle cycle.
//
// Ports:
//   clk             write-side clock
//   reset           asynchronous active-low reset (0 = in reset)
//   req             per-requester write request, held with data until granted
//   req_data        requester i's word in bits [i*DATA_BITS +: DATA_BITS]
//   grant           one-hot accept pulse; grant[i] means req_data[i] is written
//                   at this clock edge
//   owner           index of the current owner, valid while busy is high
//   busy            high while the port is owned
//   fifo_input_data word to the FIFO (zero when not writing)
//   fifo_write      FIFO write strobe
//   fifo_full       FIFO full flag
// -----------------------------------------------------------------------------
module fifo_write_arbiter #(
   parameter int unsigned DATA_BITS = 10,
   parameter int unsigned NUM_REQ   = 4,
   parameter int unsigned MAX_BURST = 4
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [NUM_REQ-1:0]           req,
   input  logic [NUM_REQ*DATA_BITS-1:0] req_data,
   output logic [NUM_REQ-1:0]           grant,
   output logic [$clog2(NUM_REQ)-1:0]   owner,
   output logic                         busy,
   output logic [DATA_BITS-1:0]         fifo_input_data,
   output logic                         fifo_write,
   input  logic                         fifo_full
);

   localparam int unsigned OwnerBits = $clog2(NUM_REQ);
   localparam int unsigned CntBits   = $clog2(MAX_BURST + 1);

   localparam logic [OwnerBits-1:0] LastIdx  = OwnerBits'(NUM_REQ - 1);
   localparam logic [CntBits-1:0]   BurstMax = CntBits'(MAX_BURST);

   // FSM state encoding
   localparam logic [0:0] StIdle  = 1'b0;
   localparam logic [0:0] StGrant = 1'b1;

   logic [0:0]           state_q, state_d;
   logic [OwnerBits-1:0] owner_q, owner_d;
   logic [OwnerBits-1:0] rr_ptr_q, rr_ptr_d;
   logic [CntBits-1:0]   burst_cnt_q, burst_cnt_d;

   logic                 owner_req;
   logic [DATA_BITS-1:0] owner_word;
   logic                 wr_ok;
   logic                 pick_found;
   logic [OwnerBits-1:0] pick_idx;
   logic [OwnerBits-1:0] next_ptr;
   logic [CntBits-1:0]   burst_inc;

   // ---------------------------------------------------------------------------
   // Owner selection of request and data. Decoded by comparison rather than a
   // variable index so an out-of-range owner simply reads as "no request".
   // ---------------------------------------------------------------------------
   always_comb begin
      owner_req  = 1'b0;
      owner_word = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (owner_q == OwnerBits'(i)) begin
            owner_req  = req[i];
            owner_word = req_data[i*DATA_BITS +: DATA_BITS];
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Circular priority search starting at rr_ptr: first pass covers indices at
   // or above the pointer, second pass wraps to the bottom.
   // ---------------------------------------------------------------------------
   always_comb begin
      pick_found = 1'b0;
      pick_idx   = '0;
      for (int j = 0; j < NUM_REQ; j++) begin
         if (!pick_found && req[j] && (OwnerBits'(j) >= rr_ptr_q)) begin
            pick_found = 1'b1;
            pick_idx   = OwnerBits'(j);
         end
      end
      for (int j = 0; j < NUM_REQ; j++) begin
         if (!pick_found && req[j]) begin
            pick_found = 1'b1;
            pick_idx   = OwnerBits'(j);
         end
      end
   end

   // Pointer to the requester after the current owner, wrapping to 0.
   assign next_ptr  = (owner_q >= LastIdx) ? '0 : owner_q + OwnerBits'(1);
   assign burst_inc = burst_cnt_q + CntBits'(1);

   assign wr_ok = (state_q == StGrant) && owner_req && !fifo_full;

   // ---------------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d     = state_q;
      owner_d     = owner_q;
      rr_ptr_d    = rr_ptr_q;
      burst_cnt_d = burst_cnt_q;
      case (state_q)
         StIdle: begin
            // Arbitrate only when the FIFO can take a word.
            if (pick_found && !fifo_full) begin
               state_d     = StGrant;
               owner_d     = pick_idx;
               burst_cnt_d = '0;
            end
         end
         StGrant: begin
            if (wr_ok) begin
               burst_cnt_d = burst_inc;
               if (burst_inc == BurstMax) begin
                  state_d  = StIdle;
                  rr_ptr_d = next_ptr;
               end
            end else if (!owner_req) begin
               // Owner is done before its burst limit.
               state_d  = StIdle;
               rr_ptr_d = next_ptr;
            end
            // Otherwise the FIFO is full: hold owner and count.
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= StIdle;
         owner_q     <= '0;
         rr_ptr_q    <= '0;
         burst_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         owner_q     <= owner_d;
         rr_ptr_q    <= rr_ptr_d;
         burst_cnt_q <= burst_cnt_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Outputs. All are functions of the registered state, so they fall to their
   // idle values as soon as reset is asserted.
   // ---------------------------------------------------------------------------
   always_comb begin
      grant = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         grant[i] = wr_ok && (owner_q == OwnerBits'(i));
      end
   end

   assign fifo_write      = wr_ok;
   assign fifo_input_data = wr_ok ? owner_word : '0;
   assign busy            = (state_q == StGrant);
   assign owner           = owner_q;

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// -----------------------------------------------------------------------------
// Self-checking bench for fifo_write_arbiter. Requesters are modelled as word
// queues; a behavioural model of the arbitration rules predicts every output
// on every cycle, and directed scenarios pin the model with literal values.
// -----------------------------------------------------------------------------
module tb_fifo_write_arbiter;

   localparam int unsigned DW = 10;
   localparam int unsigned NR = 4;
   localparam int unsigned MB = 4;
   localparam int unsigned OW = 2;

   logic              clk = 1'b0;
   logic              reset;
   logic [NR-1:0]     req;
   logic [NR*DW-1:0]  req_data;
   logic [NR-1:0]     grant;
   logic [OW-1:0]     owner;
   logic              busy;
   logic [DW-1:0]     fifo_input_data;
   logic              fifo_write;
   logic              fifo_full;

   always #5 clk = ~clk;

   fifo_write_arbiter #(
      .DATA_BITS (DW),
      .NUM_REQ   (NR),
      .MAX_BURST (MB)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .req             (req),
      .req_data        (req_data),
      .grant           (grant),
      .owner           (owner),
      .busy            (busy),
      .fifo_input_data (fifo_input_data),
      .fifo_write      (fifo_write),
      .fifo_full       (fifo_full)
   );

   int errors = 0;
   int checks = 0;

   // Requester side: pending words and whether the request is currently up.
   logic [DW-1:0] wq [NR][$];
   bit            holding [NR];
   bit            directed;
   bit            full_force;

   // Behavioural model of the port owner.
   bit m_busy;
   int m_owner;
   int m_ptr;
   int m_words;

   // Logs
   logic [DW-1:0] exp_log [$];
   logic [DW-1:0] dut_log [$];
   logic [DW-1:0] dut_words [$];
   int            dut_own [$];
   bit            write_bits [$];
   bit            busy_bits [$];

   bit            exp_wr;
   logic [NR-1:0] exp_grant;
   logic [DW-1:0] exp_data;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit all_idle();
      bit r = !m_busy;
      for (int i = 0; i < NR; i++) if (wq[i].size() != 0) r = 0;
      return r;
   endfunction

   task automatic reset_model();
      m_busy  = 0;
      m_owner = 0;
      m_ptr   = 0;
      m_words = 0;
      for (int i = 0; i < NR; i++) begin
         holding[i] = 0;
         wq[i].delete();
      end
   endtask

   task automatic clear_rec();
      dut_words.delete();
      dut_own.delete();
      write_bits.delete();
      busy_bits.delete();
   endtask

   function automatic logic [31:0] pack(input bit b[$], input int n);
      logic [31:0] v = '0;
      for (int k = 0; k < n && k < b.size(); k++) v = {v[30:0], b[k]};
      return v;
   endfunction

   // One clock cycle: drive at the falling edge, compare, then advance the
   // model across the rising edge.
   task automatic step();
      @(negedge clk);
      for (int i = 0; i < NR; i++) begin
         if (!holding[i] && wq[i].size() != 0 && (directed || $urandom_range(0, 3) != 0))
            holding[i] = 1;
         req[i] = holding[i];
         req_data[i*DW +: DW] = holding[i] ? wq[i][0] : DW'($urandom);
      end
      fifo_full = directed ? full_force : ($urandom_range(0, 3) == 0);
      #1;
      exp_wr    = m_busy && req[m_owner] && !fifo_full;
      exp_grant = exp_wr ? (NR'(1) << m_owner) : '0;
      exp_data  = exp_wr ? wq[m_owner][0] : '0;
      check("grant", 32'(grant), 32'(exp_grant));
      check("fifo_write", 32'(fifo_write), 32'(exp_wr));
      check("fifo_input_data", 32'(fifo_input_data), 32'(exp_data));
      check("busy", 32'(busy), 32'(m_busy));
      if (m_busy) check("owner", 32'(owner), 32'(m_owner));
      write_bits.push_back(fifo_write);
      busy_bits.push_back(busy);
      if (fifo_write) begin
         dut_log.push_back(fifo_input_data);
         dut_words.push_back(fifo_input_data);
         for (int i = 0; i < NR; i++) if (grant[i]) dut_own.push_back(i);
      end
      @(posedge clk);
      if (exp_wr) begin
         exp_log.push_back(wq[m_owner][0]);
         void'(wq[m_owner].pop_front());
         holding[m_owner] = 0;
         m_words++;
         if (m_words == MB) begin
            m_busy = 0;
            m_ptr  = (m_owner + 1) % NR;
         end
      end else if (m_busy && !req[m_owner]) begin
         m_busy = 0;
         m_ptr  = (m_owner + 1) % NR;
      end else if (!m_busy && req != '0 && !fifo_full) begin
         for (int k = NR - 1; k >= 0; k--) begin
            if (req[(m_ptr + k) % NR]) m_owner = (m_ptr + k) % NR;
         end
         m_busy  = 1;
         m_words = 0;
      end
   endtask

   task automatic drain(input int max_cycles, input string name);
      int n = 0;
      while (!all_idle() && n < max_cycles) begin
         step();
         n++;
      end
      check(name, 32'(all_idle()), 32'd1);
   endtask

   task automatic run_until_words(input int want, input string name);
      int n = 0;
      while (dut_words.size() < want && n < 30) begin
         step();
         n++;
      end
      check(name, 32'(dut_words.size()), 32'(want));
   endtask

   initial begin
      int bad;
      reset      = 1'b0;
      req        = '1;
      req_data   = '1;
      fifo_full  = 1'b0;
      directed   = 1;
      full_force = 0;
      reset_model();

      // Reset state, with requests asserted to show they are ignored.
      repeat (2) @(negedge clk);
      #1;
      check("reset_grant", 32'(grant), 32'd0);
      check("reset_write", 32'(fifo_write), 32'd0);
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_data", 32'(fifo_input_data), 32'd0);
      check("reset_owner", 32'(owner), 32'd0);
      req = '0;
      @(negedge clk);
      reset = 1'b1;

      // Fairness: all four request 8 words each from rr_ptr=0.
      for (int i = 0; i < NR; i++)
         for (int n = 0; n < 8; n++) wq[i].push_back(DW'(10'h200 + i * 16 + n));
      clear_rec();
      drain(200, "fair_drain");
      check("fair_count", 32'(dut_words.size()), 32'd32);
      bad = 0;
      for (int n = 0; n < dut_own.size(); n++) if (dut_own[n] != (n / 4) % 4) bad++;
      check("fair_owner_order", 32'(bad), 32'd0);

      // Single requester 2, six words, burst limit 4.
      for (int n = 0; n < 6; n++) wq[2].push_back(DW'(10'h101 + n));
      clear_rec();
      drain(40, "single_drain");
      check("single_write_pattern", pack(write_bits, 9), 32'b011110110);
      check("single_busy_pattern", pack(busy_bits, 9), 32'b011110111);
      check("single_count", 32'(dut_words.size()), 32'd6);
      bad = 0;
      for (int n = 0; n < dut_words.size(); n++) if (dut_words[n] != DW'(10'h101 + n)) bad++;
      check("single_words", 32'(bad), 32'd0);

      // Early release: rr_ptr is now 3; requester 3 sends one word, 0 waits.
      wq[3].push_back(10'h301);
      wq[0].push_back(10'h001);
      wq[0].push_back(10'h002);
      clear_rec();
      drain(40, "early_drain");
      check("early_write_pattern", pack(write_bits, 7), 32'b0100110);
      check("early_busy_pattern", pack(busy_bits, 7), 32'b0110111);
      check("early_owner_seq", (dut_own.size() == 3) ? 32'(dut_own[0] * 16 + dut_own[1] * 4 + dut_own[2])
                                                     : 32'hFFFF, 32'd48);

      // Back-pressure: owner 1, full for 5 cycles after 2 writes.
      for (int n = 0; n < 4; n++) wq[1].push_back(DW'(10'h111 + n));
      clear_rec();
      run_until_words(2, "bp_first_two");
      full_force = 1;
      repeat (5) step();
      check("bp_no_write_while_full", 32'(dut_words.size()), 32'd2);
      check("bp_busy_while_full", pack(busy_bits, busy_bits.size()) & 32'h1F, 32'h1F);
      full_force = 0;
      repeat (2) step();
      check("bp_resume_words", 32'(dut_words.size()), 32'd4);
      step();
      check("bp_burst_end_idle", 32'(busy_bits[busy_bits.size() - 1]), 32'd0);
      drain(20, "bp_drain");
      bad = 0;
      for (int n = 0; n < dut_words.size(); n++) if (dut_words[n] != DW'(10'h111 + n)) bad++;
      check("bp_words", 32'(bad + (dut_words.size() != 4)), 32'd0);

      // Full at arbitration: request from 1 while the FIFO is full.
      wq[1].push_back(10'h1A1);
      full_force = 1;
      clear_rec();
      repeat (3) step();
      check("arb_full_busy", pack(busy_bits, 3), 32'd0);
      full_force = 0;
      step();
      #1;
      check("arb_release_busy", 32'(busy), 32'd1);
      check("arb_release_owner", 32'(owner), 32'd1);
      drain(20, "arb_drain");

      // Async reset mid-burst, then arbitration must restart from rr_ptr=0.
      for (int n = 0; n < 4; n++) wq[2].push_back(DW'(10'h321 + n));
      clear_rec();
      run_until_words(2, "rst_first_two");
      @(negedge clk);
      #2;
      reset = 1'b0;
      #1;
      check("rst_grant", 32'(grant), 32'd0);
      check("rst_write", 32'(fifo_write), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      reset_model();
      req = '0;
      @(negedge clk);
      reset = 1'b1;
      wq[1].push_back(10'h3B1);
      wq[3].push_back(10'h3B3);
      clear_rec();
      drain(20, "rst_drain");
      check("rst_first_owner", (dut_own.size() != 0) ? 32'(dut_own[0]) : 32'hFF, 32'd1);

      // Randomized traffic with random back-pressure.
      directed = 0;
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 2) == 0) begin
            int r = $urandom_range(0, NR - 1);
            if (wq[r].size() < 6) wq[r].push_back(DW'($urandom));
         end
         step();
      end
      directed   = 1;
      full_force = 0;
      drain(500, "rand_drain");
      check("log_size", 32'(dut_log.size()), 32'(exp_log.size()));
      bad = 0;
      for (int n = 0; n < dut_log.size() && n < exp_log.size(); n++)
         if (dut_log[n] !== exp_log[n]) bad++;
      check("log_content", 32'(bad), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not complete, errors=%0d checks=%0d", errors, checks);
      $fatal(1, "watchdog");
   end

endmodule
